swu_pack: RTL and testbench
===========================

// Module: swu_pack
// PURPOSE
//  Write-side inverse of the sliding-window ROM reader. Accepts a stream of 7-bit
//  windows (stride 2, MSB-first) and rebuilds the underlying bit stream. Packs the
//  bits into 32-bit words and writes them to an ECG frame RAM (29 words) for later replay.
//  Checks window overlap consistency on the way in.
// PARAMETERS
//  WORD_W  32  packed word width
//  WIN_W   7   window width
//  STRIDE  2   new bits per window after the first
//  DEPTH   29  words per frame
//  ADDR_W  5   RAM address width
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  win_valid    in   1   win_data valid this cycle
//  win_first    in   1   qualifies win_valid: window is first of a new frame
//  win_data     in   7   window; bit 6 = earliest stream bit
//  wr_en        out  1   RAM write strobe, one cycle per word
//  wr_addr      out  5   RAM word address, 0..DEPTH-1
//  wr_data      out  32  packed word; bit 31 = earliest stream bit
//  frame_done   out  1   one-cycle pulse, coincident with the write of word DEPTH-1
//  overlap_err  out  1   sticky overlap mismatch flag
//  busy         out  1   high in FILL state
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; bit count 0; prev window 0.
//  States: IDLE -> FILL on win_valid&win_first. FILL -> DONE on the write of word DEPTH-1.
//   DONE -> FILL on win_valid&win_first. Any state: win_valid&win_first restarts the frame.
//  win_valid without win_first is ignored in IDLE and DONE.
//  Frame start: acc <= win_data (7 bits), count=7, wr_addr ptr=0, overlap_err cleared.
//   Any partial word from an abandoned frame is dropped; no write for it.
//  FILL, non-first window: compare win_data[6:2] with prev[4:0].
//   A mismatch sets overlap_err the next cycle.
//   win_data[1:0] is appended either way, with bit 1 first; count += 2.
//  Accumulator holds up to 33 bits (7+2k is always odd).
//   When count reaches >=32, the oldest 32 bits go to wr_data. The 33rd bit carries over
//   and count becomes 1.
//  Write timing: wr_en, wr_addr and wr_data are registered, valid the cycle after the
//   accepting edge. wr_addr increments after each write and never exceeds DEPTH-1.
//  Window counts: the first word completes on window 14. Each later word takes 16 more windows.
//   Word DEPTH-1 completes on window 462. Its leftover carry bit is discarded.
//  win_valid may have gaps of any length; there is no backpressure; one window per cycle max.
//  rst mid-frame: immediate return to IDLE. Pending wr_en is dropped and partial data is lost.
//  Simultaneous: frame_done and wr_en share a cycle. A win_first arriving in the same cycle
//   as the final write takes effect after that write is issued.
// TESTING
//  1. Serialize word 32'hA5A5_F00F plus filler. First windows are 7'h52, 7'h4B.
//     -> wr_en once after window 14, wr_addr=0, wr_data=32'hA5A5_F00F, overlap_err=0.
//  2. Full frame: 29 random words as 462 windows. Each word is 16 windows after the previous.
//     -> 29 writes at addr 0..28 with matching data; frame_done with the addr-28 write;
//        busy=0 afterwards.
//  3. Send 7'h52 then 7'h4F. Bits [6:2]=10011 vs 10010.
//     -> overlap_err=1 the next cycle and stays 1. It clears on the next win_first.
//  4. Insert 0-5 idle cycles randomly between windows of scenario 2 -> identical write sequence.
//  5. win_first after window 20 of a frame.
//     -> word 0 already written, no partial write, wr_addr restarts at 0.
//  6. Assert rst while wr_en is pending -> all outputs 0 asynchronously, no write issued.
//     Windows after DONE without win_first -> no wr_en.

Source files
------------

// File: rtl/swu_pack.sv
// Rebuilds a bit stream from overlapping 7-bit windows (stride 2) and packs it into 32-bit RAM words.
// Latency: each write is registered and appears one cycle after the window that completes the word.
// Backpressure: none; at most one window per cycle, gaps of any length; no-first windows outside FILL are dropped.
module swu_pack #(
  parameter int WORD_W = 32,
  parameter int WIN_W  = 7,
  parameter int STRIDE = 2,
  parameter int DEPTH  = 29,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              win_valid,
  input  logic              win_first,
  input  logic [WIN_W-1:0]  win_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              frame_done,
  output logic              overlap_err,
  output logic              busy
);

  // The accumulator needs one spare bit: window counts make the fill level odd,
  // so a word completes at 33 bits with one bit carried into the next word.
  localparam int ACC_W  = WORD_W + 1;
  localparam int CNT_W  = $clog2(ACC_W + 1);
  localparam int TAIL_W = WIN_W - STRIDE;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              state, next_state;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    count;
  logic [ADDR_W-1:0]   ptr;
  logic [TAIL_W-1:0]   prev_tail;

  logic                start;
  logic                take;
  logic                word_ready;
  logic                last_word;
  logic                mismatch;
  logic [ACC_W-1:0]    shifted;
  logic [CNT_W-1:0]    cnt_sum;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Window decode, word completion and next-state selection
  always_comb begin
    start      = win_valid & win_first;
    take       = win_valid & ~win_first & (state == FILL);
    shifted    = {acc[ACC_W-STRIDE-1:0], win_data[STRIDE-1:0]};
    cnt_sum    = count + CNT_W'(STRIDE);
    word_ready = take && (cnt_sum >= CNT_W'(ACC_W));
    last_word  = word_ready && (ptr == ADDR_W'(DEPTH - 1));
    mismatch   = take && (win_data[WIN_W-1:STRIDE] != prev_tail);
    next_state = state;
    if (start)          next_state = FILL;
    else if (last_word) next_state = DONE;
  end

  // Datapath: accumulator, write port registers and sticky overlap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      count       <= '0;
      ptr         <= '0;
      prev_tail   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      wr_en      <= word_ready;
      frame_done <= last_word;
      if (word_ready) begin
        wr_addr <= ptr;
        wr_data <= shifted[ACC_W-1:1];
      end
      if (start) begin
        // A new frame drops any partial word left from an abandoned one.
        acc         <= {{(ACC_W-WIN_W){1'b0}}, win_data};
        count       <= CNT_W'(WIN_W);
        ptr         <= '0;
        overlap_err <= 1'b0;
        prev_tail   <= win_data[TAIL_W-1:0];
      end else if (take) begin
        prev_tail <= win_data[TAIL_W-1:0];
        if (mismatch) overlap_err <= 1'b1;
        if (word_ready) begin
          acc   <= {{(ACC_W-1){1'b0}}, shifted[0]};
          count <= CNT_W'(1);
          if (ptr != ADDR_W'(DEPTH - 1)) ptr <= ptr + ADDR_W'(1);
        end else begin
          acc   <= shifted;
          count <= cnt_sum;
        end
      end
    end
  end

  assign busy = (state == FILL);

endmodule

// File: tb/tb_swu_pack.sv
// Scoreboard bench for swu_pack: directed window streams, expected writes queued, monitor compares.
module tb_swu_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        win_valid = 1'b0;
  logic        win_first = 1'b0;
  logic [6:0]  win_data = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        frame_done;
  logic        overlap_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] words[29];
  bit          stream[960];

  swu_pack dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .win_first(win_first),
    .win_data(win_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .overlap_err(overlap_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every write the DUT presents is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", wr_data, e.data);
        check("frame_done", 32'(frame_done), 32'(e.done));
      end
    end else if (!rst && frame_done) begin
      total++;
      bad++;
      $display("FAIL frame_done_alone: got 1 expected 0 without wr_en");
    end
  end

  task automatic build_stream();
    for (int w = 0; w < 29; w++)
      for (int b = 0; b < 32; b++)
        stream[32*w+b] = words[w][31-b];
    for (int k = 928; k < 960; k++) stream[k] = bit'($urandom_range(0, 1));
  endtask

  function automatic logic [6:0] window_at(input int i);
    logic [6:0] d;
    for (int k = 0; k < 7; k++) d[6-k] = stream[2*i+k];
    return d;
  endfunction

  task automatic send_win(input logic [6:0] d, input logic f);
    win_valid = 1'b1; win_first = f; win_data = d;
    @(posedge clk); #1;
    win_valid = 1'b0; win_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_words(input int n);
    for (int w = 0; w < n; w++) begin
      exp_t e;
      e.addr = 5'(w); e.data = words[w]; e.done = (w == 28);
      expq.push_back(e);
    end
  endtask

  task automatic send_frame(input int nwin, input int maxgap);
    for (int i = 0; i < nwin; i++) begin
      send_win(window_at(i), i == 0);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic drain();
    int budget = 0;
    while (expq.size() != 0 && budget < 50) begin idle(1); budget++; end
    idle(2);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overlap_err", 32'(overlap_err), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(1);

    // Test 1: known first word
    words[0] = 32'hA5A5_F00F;
    for (int w = 1; w < 29; w++) words[w] = $urandom;
    build_stream();
    check("t1_win0", 32'(window_at(0)), 32'h52);
    check("t1_win1", 32'(window_at(1)), 32'h4B);
    push_words(1);
    send_frame(14, 0);
    check("t1_busy", 32'(busy), 1);
    drain();
    check("t1_overlap_err", 32'(overlap_err), 0);

    // Test 3: overlap mismatch, sticky, cleared by next first window
    send_win(7'h52, 1'b1);
    check("t3_err_before", 32'(overlap_err), 0);
    send_win(7'h4F, 1'b0);
    check("t3_err_set", 32'(overlap_err), 1);
    idle(3);
    check("t3_err_sticky", 32'(overlap_err), 1);
    send_win(7'h11, 1'b1);
    check("t3_err_cleared", 32'(overlap_err), 0);

    // Test 2: full frame, back-to-back windows
    for (int w = 0; w < 29; w++) words[w] = $urandom;
    build_stream();
    push_words(29);
    send_frame(462, 0);
    check("t2_busy_after", 32'(busy), 0);
    drain();

    // Test 4: same frame with random idle gaps
    push_words(29);
    send_frame(462, 5);
    check("t4_busy_after", 32'(busy), 0);
    drain();

    // Windows after DONE without a first flag must not write
    for (int i = 0; i < 40; i++) send_win(7'(i * 3), 1'b0);
    check("done_busy", 32'(busy), 0);
    idle(3);

    // Test 5: abandon after window 20, restart writes from addr 0
    for (int w = 0; w < 29; w++) words[w] = $urandom;
    build_stream();
    push_words(1);
    send_frame(20, 0);
    drain();
    for (int w = 0; w < 29; w++) words[w] = $urandom;
    build_stream();
    push_words(1);
    send_frame(14, 0);
    drain();

    // Test 6: reset while a write is on the port
    for (int w = 0; w < 29; w++) words[w] = $urandom;
    build_stream();
    send_frame(13, 0);
    win_valid = 1'b1; win_first = 1'b0; win_data = window_at(13);
    @(posedge clk); #1;
    win_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_wr_en", 32'(wr_en), 0);
    check("t6_wr_data", wr_data, 0);
    check("t6_busy", 32'(busy), 0);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 10; i++) send_win(7'(i * 5), 1'b0);
    idle(3);

    check("queue_empty", 32'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
